// File: rtl/dual_rail_decoder_if.sv
// Dual-rail receive bus: q/qn lane pairs in, decoded word and status out.
// master = the side that drives the rails, slave = the decoder.
interface dual_rail_decoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             fault_clr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             fault;
  logic             busy;

  modport master (
    output q, qn, fault_clr,
    input  data_out, data_valid, fault, busy
  );

  modport slave (
    input  q, qn, fault_clr,
    output data_out, data_valid, fault, busy
  );
endinterface

// File: rtl/dual_rail_decoder.sv
// 4-phase return-to-spacer dual-rail decoder with illegal-code and stall detection.
// Define DUAL_RAIL_ERR_CNT_EN to add the saturating fault-event counter err_cnt.
module dual_rail_decoder #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
`ifdef DUAL_RAIL_ERR_CNT_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  dual_rail_decoder_if.slave      bus
`ifdef DUAL_RAIL_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]        err_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_SPACER,
    ST_DATA,
    ST_FAULT
  } state_t;

  state_t           state;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             fault_r;
  logic             busy_r;

  logic any_illegal;
  logic all_spacer;
  logic all_valid;
  logic stalled;
  logic go_fault;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    any_illegal = |(bus.q & bus.qn);
    all_spacer  = ~|(bus.q | bus.qn);
    all_valid   = &(bus.q ^ bus.qn);
    // A mixed word on the same sample that would make the stall count reach TIMEOUT.
    stalled     = (state == ST_DATA) && !all_valid && !all_spacer &&
                  (tcnt == TW'(TIMEOUT - 1));
    go_fault    = (state != ST_FAULT) && (any_illegal || stalled);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_SPACER;
      tcnt    <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef DUAL_RAIL_ERR_CNT_EN
      err_cnt <= '0;
`endif
    end else begin
      valid_r <= 1'b0;
      if (go_fault) begin
        state   <= ST_FAULT;
        fault_r <= 1'b1;
        busy_r  <= 1'b0;
        tcnt    <= '0;
`ifdef DUAL_RAIL_ERR_CNT_EN
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
      end else begin
        unique case (state)
          ST_SPACER: begin
            if (all_spacer) begin
              state  <= ST_DATA;
              busy_r <= 1'b1;
            end
          end
          ST_DATA: begin
            if (all_valid) begin
              data_r  <= bus.q;
              valid_r <= 1'b1;
              state   <= ST_SPACER;
              busy_r  <= 1'b0;
              tcnt    <= '0;
            end else if (!all_spacer) begin
              tcnt <= tcnt + 1'b1;
            end
          end
          ST_FAULT: begin
            if (bus.fault_clr) begin
              state   <= ST_SPACER;
              fault_r <= 1'b0;
            end
          end
          default: state <= ST_SPACER;
        endcase
      end
    end
  end

  assign bus.data_out   = data_r;
  assign bus.data_valid = valid_r;
  assign bus.fault      = fault_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_dual_rail_decoder.sv
// Randomized self-checking bench for dual_rail_decoder against a lane-counting reference model.
module tb_dual_rail_decoder;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int ERR_MAX = 255;

  logic clk = 1'b0;
  logic reset_n;

  dual_rail_decoder_if #(.WIDTH(WIDTH)) bus ();

`ifdef DUAL_RAIL_ERR_CNT_EN
  logic [7:0] err_cnt;
  dual_rail_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );
`else
  dual_rail_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: "armed" means a full spacer has been seen and a word is awaited.
  bit         m_armed;
  bit         m_faulted;
  int         m_stall;
  int         m_errs;
  logic [7:0] m_data;
  bit         m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_armed = 0; m_faulted = 0; m_stall = 0; m_errs = 0; m_data = '0; m_valid = 0;
  endtask

  task automatic model_fault();
    m_faulted = 1;
    m_armed   = 0;
    m_stall   = 0;
    if (m_errs < ERR_MAX) m_errs++;
  endtask

  task automatic model_step(input logic [7:0] tq, input logic [7:0] tqn, input logic clr);
    int n_sp, n_val, n_bad;
    n_sp = 0; n_val = 0; n_bad = 0;
    for (int i = 0; i < WIDTH; i++) begin
      case ({tq[i], tqn[i]})
        2'b00:   n_sp++;
        2'b11:   n_bad++;
        default: n_val++;
      endcase
    end
    m_valid = 0;
    if (m_faulted) begin
      if (clr) m_faulted = 0;
    end else if (n_bad > 0) begin
      model_fault();
    end else if (!m_armed) begin
      if (n_sp == WIDTH) m_armed = 1;
    end else if (n_val == WIDTH) begin
      m_data  = tq;
      m_valid = 1;
      m_armed = 0;
      m_stall = 0;
    end else if (n_sp != WIDTH) begin
      m_stall++;
      if (m_stall >= TIMEOUT) model_fault();
    end
  endtask

  task automatic compare_all();
    check("data_out",   32'(bus.data_out),   32'(m_data));
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("fault",      32'(bus.fault),      32'(m_faulted));
    check("busy",       32'(bus.busy),       32'(m_armed && !m_faulted));
`ifdef DUAL_RAIL_ERR_CNT_EN
    check("err_cnt",    32'(err_cnt),        32'(m_errs));
`endif
  endtask

  task automatic step(input logic [7:0] tq, input logic [7:0] tqn, input logic clr);
    bus.q = tq; bus.qn = tqn; bus.fault_clr = clr;
    @(posedge clk);
    model_step(tq, tqn, clr);
    #1;
    compare_all();
  endtask

  task automatic word(input logic [7:0] w);
    step(w, ~w, 1'b0);
  endtask

  task automatic spacer();
    step(8'h00, 8'h00, 1'b0);
  endtask

  // Random per-lane code: 0 spacer, 1 bit-0, 2 bit-1; never illegal.
  task automatic rand_partial(output logic [7:0] tq, output logic [7:0] tqn);
    for (int i = 0; i < WIDTH; i++) begin
      int c;
      c = int'($urandom_range(0, 2));
      tq[i]  = (c == 2);
      tqn[i] = (c == 1);
    end
  endtask

  initial begin
    logic [7:0] tq, tqn, w;
    int         r;

    // T1: reset held with random rails.
    reset_n = 1'b0;
    bus.q = 8'($urandom); bus.qn = 8'($urandom); bus.fault_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    #3 reset_n = 1'b1;

    // T2: single word A5.
    spacer();
    step(8'hA5, 8'h5A, 1'b0);
    check("t2_word", 32'(bus.data_out), 32'h0000_00A5);
    spacer();
    spacer();

    // T3: illegal lane 3 mid-word, then clear.
    step(8'h0C, 8'h08, 1'b0);
    check("t3_fault", 32'(bus.fault), 32'd1);
    step(8'hFF, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b1);
    check("t3_clr", 32'(bus.fault), 32'd0);
    spacer();

    // T4: 16 stalled samples fault; 15 stalled then completion does not.
    for (int i = 0; i < TIMEOUT; i++) step(8'h01, 8'h00, 1'b0);
    check("t4_timeout", 32'(bus.fault), 32'd1);
    step(8'h00, 8'h00, 1'b1);
    spacer();
    for (int i = 0; i < TIMEOUT - 1; i++) step(8'h01, 8'h00, 1'b0);
    word(8'h3C);
    check("t4_late_word", 32'(bus.data_valid), 32'd1);

    // T5: back-to-back words with one spacer sample.
    spacer();
    word(8'h0F);
    spacer();
    word(8'hF0);
    check("t5_second", 32'(bus.data_out), 32'h0000_00F0);

    // T6: reset mid-word discards the word.
    spacer();
    step(8'h11, 8'h02, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    bus.q = 8'h55; bus.qn = 8'hAA;
    @(posedge clk);
    #1 compare_all();
    #2 reset_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        tq = 8'h00; tqn = 8'h00;
      end else if (r < 60) begin
        w = 8'($urandom); tq = w; tqn = ~w;
      end else if (r < 96) begin
        rand_partial(tq, tqn);
      end else begin
        tq = 8'($urandom) | 8'h40; tqn = 8'($urandom) | 8'h40;
      end
      step(tq, tqn, ($urandom_range(0, 9) == 0));
    end

`ifdef DUAL_RAIL_ERR_CNT_EN
    // Saturation: 300 more fault events from a clean start.
    step(8'h00, 8'h00, 1'b1);
    for (int n = 0; n < 300; n++) begin
      step(8'h08, 8'h08, 1'b0);
      step(8'h00, 8'h00, 1'b1);
    end
    check("err_sat", 32'(err_cnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
